// File: rtl/bmult_pipe_hs.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready handshakes on both sides.
// Signed or unsigned per transaction; a sideband tag travels alongside each product.
module bmult_pipe_hs #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [STAGES-1:0] vld_q;
    logic [PW-1:0]     prod_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    logic          adv;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod_in;

    // The whole pipeline moves together; only a held output result stalls it.
    assign adv      = !(vld_q[STAGES-1] && !out_ready);
    assign in_ready = adv;

    // Extending to 2*WIDTH first makes the low half of the product exact in both modes.
    always_comb begin
        a_ext   = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext   = signed_mode ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod_in = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[0]  <= 1'b0;
            prod_q[0] <= '0;
            tag_q[0]  <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                prod_q[0] <= prod_in;
                tag_q[0]  <= in_tag;
            end
        end
    end

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[i]  <= 1'b0;
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end else if (adv) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    prod_q[i] <= prod_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                end
            end
        end
    end

    // Data only loads behind a valid item, so the last delivered result persists when idle.
    assign out_valid = vld_q[STAGES-1];
    assign p         = prod_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_bmult_pipe_hs.sv
// Scoreboard bench for bmult_pipe_hs: a 32x32/3-stage instance with directed and random
// traffic, plus an 8x8/1-stage instance under random handshakes.
module tb_bmult_pipe_hs;

    localparam int S_MAIN  = 3;
    localparam int S_SMALL = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- main instance: WIDTH=32, STAGES=3 ----------------
    logic        in_valid, in_ready, sm, out_valid;
    logic [31:0] a, b;
    logic [3:0]  in_tag, out_tag;
    logic [63:0] p;
    logic        rdy_d, rdy_r, rdy_rand;
    logic        out_ready;
    assign out_ready = rdy_rand ? rdy_r : rdy_d;
    always @(posedge clk) begin
        #1 rdy_r = ($urandom_range(3) != 0);
    end

    bmult_pipe_hs #(.WIDTH(32), .STAGES(S_MAIN), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .signed_mode(sm), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .out_tag(out_tag)
    );

    typedef struct { logic [63:0] p; logic [3:0] tag; int cyc; int st; } exp_t;
    typedef struct { logic [63:0] p; logic [3:0] tag; int cyc; } log_t;
    exp_t exp_q[$];
    log_t log_q[$];
    int   stall_cnt = 0;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic m);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (m) return sx * sy;
        return ux * uy;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready)
                exp_q.push_back('{ref_mul(a, b, sm), in_tag, cyc, stall_cnt});
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("product", p, e.p);
                    chk("tag", 64'(out_tag), 64'(e.tag));
                    if (e.st == stall_cnt) chk("latency", 64'(cyc - e.cyc), 64'(S_MAIN));
                    log_q.push_back('{p, out_tag, cyc});
                end
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tm,
                        input logic [3:0] tt);
        int n = 0;
        a = ta; b = tb; sm = tm; in_tag = tt; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- small instance: WIDTH=8, STAGES=1 ----------------
    logic        s_in_valid, s_in_ready, s_sm, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b;
    logic [3:0]  s_in_tag, s_out_tag;
    logic [15:0] s_p;

    bmult_pipe_hs #(.WIDTH(8), .STAGES(S_SMALL), .TAG_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a),
        .b(s_b), .signed_mode(s_sm), .in_tag(s_in_tag), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .p(s_p), .out_tag(s_out_tag)
    );

    typedef struct { logic [15:0] p; logic [3:0] tag; int cyc; int st; } sexp_t;
    sexp_t s_q[$];
    int    s_stall = 0;
    int    s_acc = 0;

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                         input logic m);
        int r;
        if (m) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        sexp_t e;
        if (rst_n) begin
            if (s_in_valid && s_in_ready) begin
                s_q.push_back('{ref8(s_a, s_b, s_sm), s_in_tag, cyc, s_stall});
                s_acc++;
            end
            if (s_out_valid && !s_out_ready) s_stall++;
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    chk("s_unexpected_output", 64'(s_out_valid), 64'd0);
                end else begin
                    e = s_q.pop_front();
                    chk("s_product", 64'(s_p), 64'(e.p));
                    chk("s_tag", 64'(s_out_tag), 64'(e.tag));
                    if (e.st == s_stall) chk("s_latency", 64'(cyc - e.cyc), 64'(S_SMALL));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] hold_p;
    logic [3:0]  hold_tag;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sm = 1'b0; in_tag = '0;
        rdy_d = 1'b1; rdy_rand = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_sm = 1'b0; s_in_tag = '0; s_out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_p", p, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // unsigned max * max
        log_q.delete();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5);
        drain(50);
        chk("t1_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) begin
            chk("t1_p", log_q[0].p, 64'hFFFF_FFFE_0000_0001);
            chk("t1_tag", 64'(log_q[0].tag), 64'd5);
        end

        // signed corners, back to back
        log_q.delete();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd1);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2);
        send(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 4'd3);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd4);
        drain(50);
        chk("t2_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() >= 4) begin
            chk("t2_p0", log_q[0].p, 64'h0000_0000_0000_0001);
            chk("t2_p1", log_q[1].p, 64'h4000_0000_0000_0000);
            chk("t2_p2", log_q[2].p, 64'hFFFF_FFFF_FFFF_FFFA);
            chk("t2_p3", log_q[3].p, 64'hC000_0000_8000_0000);
            for (int i = 0; i < 4; i++) begin
                chk("t2_tag", 64'(log_q[i].tag), 64'(i + 1));
                chk("t2_consecutive", 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
            end
        end

        // backpressure: 6 transactions, out_ready low for 5 cycles once out_valid rises
        log_q.delete();
        rdy_d = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom), 4'(8 + i));
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_valid_rise", 64'(out_valid), 64'd1);
                hold_p = p;
                hold_tag = out_tag;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("bp_valid_held", 64'(out_valid), 64'd1);
                    chk("bp_p_stable", p, hold_p);
                    chk("bp_tag_stable", 64'(out_tag), 64'(hold_tag));
                    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1 rdy_d = 1'b1;
            end
        join
        drain(100);
        chk("bp_count", 64'(log_q.size()), 64'd6);
        for (int i = 0; i < log_q.size(); i++) chk("bp_order", 64'(log_q[i].tag), 64'(8 + i));

        // mixed mode, equal operands
        log_q.delete();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd6);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd7);
        drain(50);
        chk("mix_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() >= 2) begin
            chk("mix_unsigned", log_q[0].p, 64'hFFFF_FFFE_0000_0001);
            chk("mix_signed", log_q[1].p, 64'h0000_0000_0000_0001);
        end

        // reset with two transactions in flight
        send(32'd1234, 32'd5678, 1'b0, 4'd2);
        send(32'd9, 32'd10, 1'b1, 4'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_p", p, 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        exp_q.delete();
        log_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(log_q.size()), 64'd0);
        send(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd9);
        drain(50);
        chk("midrst_new_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) chk("midrst_new_p", log_q[0].p, 64'hFFFF_FFFF_FFFF_FFFE);

        // random traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) begin
                @(posedge clk);
                #1;
            end
            send(pick32(), pick32(), 1'($urandom), 4'($urandom));
        end
        drain(2000);
        rdy_rand = 1'b0;
        rdy_d = 1'b1;

        // small instance: random operands, modes and handshakes
        begin
            int n = 0;
            while (s_acc < 3000 && n < 20000) begin
                s_in_valid  = ($urandom_range(3) != 0);
                s_a         = 8'($urandom);
                s_b         = 8'($urandom);
                s_sm        = 1'($urandom);
                s_in_tag    = 4'($urandom);
                s_out_ready = ($urandom_range(3) != 0);
                @(posedge clk);
                #1;
                n++;
            end
            chk("s_accept_count", 64'(s_acc >= 3000), 64'd1);
            s_in_valid = 1'b0;
            s_out_ready = 1'b1;
            n = 0;
            while (s_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("s_drain", 64'(s_q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
